product_accumulator: RTL and testbench
======================================

# product_accumulator

Downstream consumer of the sequential Booth multiplier datapath. It accepts signed products one at a time over a valid/ready handshake and sums DOT_LEN consecutive products into one signed, saturating dot-product result. It presents that result over a second valid/ready handshake and holds it until the consumer accepts it.

## Interface
Parameters:
- MUL_WIDTH, 16, operand width of the multiplier; products are 2*MUL_WIDTH bits.
- ACC_WIDTH, 2*MUL_WIDTH+8, accumulator width; must be >= 2*MUL_WIDTH.
- DOT_LEN, 4, number of products summed per result; must be >= 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous clear of accumulator, count and state; takes priority over both handshakes.
- product_valid  input  1  product is valid this cycle.
- product_ready  output  1  block can accept a product this cycle.
- product  input  2*MUL_WIDTH  signed product from the multiplier.
- acc_valid  output  1  result is valid.
- acc_ready  input  1  consumer accepts the result.
- acc_out  output  ACC_WIDTH  signed accumulated result.
- acc_overflow  output  1  the presented result saturated at least once during accumulation.

## Operation
- FSM has two states.
  - ACCUM: product_ready=1, acc_valid=0.
  - OUTPUT: product_ready=0, acc_valid=1.
- Product handshake: a product is accepted when product_valid and product_ready are both 1 on a rising edge.
- On each accepted product:
  - acc <= sat(acc + sign_extend(product)), where sat clamps to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - count <= count+1.
  - ovf <= ovf | (clamp occurred).
- Transition to OUTPUT: on the handshake where count == DOT_LEN-1, the FSM moves to OUTPUT. The count register is $clog2(DOT_LEN)+1 bits wide and returns to 0.
- In OUTPUT, acc_out and acc_overflow are held stable until acc_valid & acc_ready.
- Result handshake: on acc_valid & acc_ready the FSM returns to ACCUM with acc=0 and ovf=0.
- Back-pressure: while in OUTPUT, product_valid is ignored (product_ready=0); the producer must hold its data.
- clear=1: on the next edge, state=ACCUM, acc=0, count=0, ovf=0, acc_valid=0. A pending result is discarded, and any product or result handshake in the same cycle is ignored.
- Reset (rst=0, at any time including mid-accumulation): state=ACCUM, acc=0, count=0, ovf=0.
- Reset values of outputs: product_ready=1 (deasserted while rst=0), acc_valid=0, acc_out=0, acc_overflow=0.
- DOT_LEN=1: every accepted product produces a result, sign-extended and never saturated.
- acc_out is a registered output, driven directly from the acc register.

## Timing
- Latency: acc_valid rises on the clock edge that accepts the DOT_LEN-th product, i.e. 1 cycle after that product is presented.
- Throughput: at most one result per DOT_LEN+1 cycles. A product cannot be accepted in the same cycle as a result handshake.
- product_ready is a combinational decode of state only (and of rst). It has no combinational path from product_valid or acc_ready.
- acc_valid, once high, stays high until the handshake, clear, or reset.
- Gaps in product_valid are allowed; accumulation simply waits.

## Test plan
- Basic sum: defaults; products 100, -30, 7, 3 back-to-back.
  - acc_valid=1 on the edge accepting the 4th product.
  - acc_out=80, acc_overflow=0.
- Back-pressure: repeat the basic sum with acc_ready=0 for 5 cycles after acc_valid rises.
  - acc_out=80 stays stable and product_ready=0 throughout.
  - After acc_ready=1 for one cycle: acc_valid=0 next cycle, product_ready=1.
- Saturation: MUL_WIDTH=4, ACC_WIDTH=9; products 64, 64, 64, 64.
  - acc_out=255, acc_overflow=1.
  - Next set 1, 1, 1, 1 gives acc_out=4, acc_overflow=0.
- Clear mid-operation: accept 10, 20; assert clear for 1 cycle; then accept 1, 2, 3, 4.
  - acc_out=10. The clear cycle's product is not counted.
- Reset mid-operation: accept 5, 5, 5; pulse rst low asynchronously (between edges).
  - Outputs are immediately acc_valid=0, acc_out=0.
  - Then 1, 1, 1, 1 gives acc_out=4.
- DOT_LEN=1 with gaps: products -7 (gap 2 cycles) then 9.
  - Two results, -7 then 9, each with acc_overflow=0.
  - Each is presented 1 cycle after acceptance.

Source files
------------

// File: rtl/product_accumulator_if.sv
// Product-in / result-out handshake bundle for product_accumulator.
interface product_accumulator_if #(
    parameter int unsigned MUL_WIDTH = 16,
    parameter int unsigned ACC_WIDTH = 2 * MUL_WIDTH + 8
);
    localparam int unsigned PROD_WIDTH = 2 * MUL_WIDTH;

    logic                  product_valid;
    logic                  product_ready;
    logic [PROD_WIDTH-1:0] product;
    logic                  acc_valid;
    logic                  acc_ready;
    logic [ACC_WIDTH-1:0]  acc_out;
    logic                  acc_overflow;

    modport slave (
        input  product_valid, product, acc_ready,
        output product_ready, acc_valid, acc_out, acc_overflow
    );

    modport master (
        output product_valid, product, acc_ready,
        input  product_ready, acc_valid, acc_out, acc_overflow
    );
endinterface

// File: rtl/product_accumulator.sv
// Sums DOT_LEN signed products into one saturating dot-product result and
// holds it on a valid/ready handshake until the consumer takes it.
module product_accumulator #(
    parameter int unsigned MUL_WIDTH = 16,
    parameter int unsigned ACC_WIDTH = 2 * MUL_WIDTH + 8,
    parameter int unsigned DOT_LEN   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    product_accumulator_if.slave  bus
);
    localparam int unsigned CNT_WIDTH = $clog2(DOT_LEN) + 1;
    localparam int unsigned SUM_WIDTH = ACC_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DOT_LEN - 1);
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic {
        ST_ACCUM  = 1'b0,
        ST_OUTPUT = 1'b1
    } state_e;

    state_e                        state_q, state_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic        [CNT_WIDTH-1:0]   count_q, count_d;
    logic                          ovf_q, ovf_d;

    logic signed [SUM_WIDTH-1:0]   sum;
    logic signed [ACC_WIDTH-1:0]   acc_sat;
    logic                          clamp_hi;
    logic                          clamp_lo;

    // One guard bit above the accumulator exposes overflow in either direction.
    always_comb begin
        sum      = SUM_WIDTH'(acc_q) + SUM_WIDTH'($signed(bus.product));
        clamp_hi = (sum[SUM_WIDTH-1:SUM_WIDTH-2] == 2'b01);
        clamp_lo = (sum[SUM_WIDTH-1:SUM_WIDTH-2] == 2'b10);
        if (clamp_hi) begin
            acc_sat = ACC_MAX;
        end else if (clamp_lo) begin
            acc_sat = ACC_MIN;
        end else begin
            acc_sat = ACC_WIDTH'(sum);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_ACCUM;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Clear outranks both handshakes.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;

        if (clear) begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_ACCUM: begin
                    if (bus.product_valid) begin
                        acc_d = acc_sat;
                        ovf_d = ovf_q | clamp_hi | clamp_lo;
                        if (count_q == CNT_LAST) begin
                            count_d = '0;
                            state_d = ST_OUTPUT;
                        end else begin
                            count_d = count_q + CNT_WIDTH'(1);
                        end
                    end
                end
                ST_OUTPUT: begin
                    if (bus.acc_ready) begin
                        state_d = ST_ACCUM;
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: state_d = ST_ACCUM;
            endcase
        end
    end

    assign bus.product_ready = rst && (state_q == ST_ACCUM);
    assign bus.acc_valid     = (state_q == ST_OUTPUT);
    assign bus.acc_out       = acc_q;
    assign bus.acc_overflow  = ovf_q;
endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: three configurations (default,
// narrow saturating, single-product) checked against a list-folding model.
module tb_product_accumulator;
    typedef logic signed [63:0] val_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic pv [3];
    logic ar [3];
    logic clr [3];
    val_t prod [3];

    logic rdy [3];
    logic av [3];
    logic aovf [3];
    val_t ao [3];

    product_accumulator_if #(.MUL_WIDTH(16), .ACC_WIDTH(40)) if0 ();
    product_accumulator_if #(.MUL_WIDTH(4),  .ACC_WIDTH(9))  if1 ();
    product_accumulator_if #(.MUL_WIDTH(16), .ACC_WIDTH(40)) if2 ();

    assign if0.product_valid = pv[0];
    assign if0.product       = 32'(prod[0]);
    assign if0.acc_ready     = ar[0];
    assign if1.product_valid = pv[1];
    assign if1.product       = 8'(prod[1]);
    assign if1.acc_ready     = ar[1];
    assign if2.product_valid = pv[2];
    assign if2.product       = 32'(prod[2]);
    assign if2.acc_ready     = ar[2];

    always_comb begin
        rdy[0]  = if0.product_ready;
        av[0]   = if0.acc_valid;
        aovf[0] = if0.acc_overflow;
        ao[0]   = val_t'($signed(if0.acc_out));
        rdy[1]  = if1.product_ready;
        av[1]   = if1.acc_valid;
        aovf[1] = if1.acc_overflow;
        ao[1]   = val_t'($signed(if1.acc_out));
        rdy[2]  = if2.product_ready;
        av[2]   = if2.acc_valid;
        aovf[2] = if2.acc_overflow;
        ao[2]   = val_t'($signed(if2.acc_out));
    end

    product_accumulator #(.MUL_WIDTH(16), .ACC_WIDTH(40), .DOT_LEN(4)) dut0 (
        .clk(clk), .rst(rst), .clear(clr[0]), .bus(if0));
    product_accumulator #(.MUL_WIDTH(4), .ACC_WIDTH(9), .DOT_LEN(4)) dut1 (
        .clk(clk), .rst(rst), .clear(clr[1]), .bus(if1));
    product_accumulator #(.MUL_WIDTH(16), .ACC_WIDTH(40), .DOT_LEN(1)) dut2 (
        .clk(clk), .rst(rst), .clear(clr[2]), .bus(if2));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input val_t act, input val_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int dl(input int k);
        return (k == 2) ? 1 : 4;
    endfunction

    function automatic int aw(input int k);
        return (k == 1) ? 9 : 40;
    endfunction

    // Model: products collected per group; result = saturating left fold.
    val_t mq [3][8];
    int   mc [3];
    bit   mpend [3];
    val_t mres [3];
    bit   mrovf [3];

    task automatic fold(input int k, input int n, output val_t s, output bit o);
        val_t hi;
        val_t lo;
        hi = (val_t'(1) <<< (aw(k) - 1)) - 1;
        lo = -(val_t'(1) <<< (aw(k) - 1));
        s = 0;
        o = 1'b0;
        for (int i = 0; i < n; i++) begin
            s = s + mq[k][i];
            if (s > hi) begin
                s = hi;
                o = 1'b1;
            end else if (s < lo) begin
                s = lo;
                o = 1'b1;
            end
        end
    endtask

    always @(posedge clk or negedge rst) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst || clr[k]) begin
                mc[k]    = 0;
                mpend[k] = 1'b0;
            end else if (mpend[k]) begin
                if (ar[k]) mpend[k] = 1'b0;
            end else if (pv[k]) begin
                mq[k][mc[k]] = prod[k];
                mc[k]++;
                if (mc[k] == dl(k)) begin
                    fold(k, mc[k], mres[k], mrovf[k]);
                    mpend[k] = 1'b1;
                    mc[k]    = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin : cmp
            val_t e;
            bit   eo;
            if (mpend[k]) begin
                e  = mres[k];
                eo = mrovf[k];
            end else begin
                fold(k, mc[k], e, eo);
            end
            chk($sformatf("model_ready%0d", k), val_t'(rdy[k]), val_t'(rst && !mpend[k]));
            chk($sformatf("model_valid%0d", k), val_t'(av[k]), val_t'(mpend[k]));
            chk($sformatf("model_acc%0d", k), ao[k], e);
            if (mpend[k]) chk($sformatf("model_ovf%0d", k), val_t'(aovf[k]), val_t'(eo));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int k, input val_t v);
        prod[k] = v;
        pv[k]   = 1'b1;
        tick();
        pv[k]   = 1'b0;
    endtask

    task automatic expect_result(input string nm, input int k, input val_t v, input bit o);
        chk({nm, "_valid"}, val_t'(av[k]), 1);
        chk({nm, "_acc"}, ao[k], v);
        chk({nm, "_ovf"}, val_t'(aovf[k]), val_t'(o));
    endtask

    task automatic ack(input string nm, input int k);
        ar[k] = 1'b1;
        tick();
        ar[k] = 1'b0;
        chk({nm, "_ack_valid"}, val_t'(av[k]), 0);
        chk({nm, "_ack_ready"}, val_t'(rdy[k]), 1);
    endtask

    initial begin
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            pv[k]   = 1'b0;
            ar[k]   = 1'b0;
            clr[k]  = 1'b0;
            prod[k] = 0;
        end
        #1;
        chk("reset_ready", val_t'(rdy[0]), 0);
        chk("reset_valid", val_t'(av[0]), 0);
        chk("reset_acc", ao[0], 0);
        chk("reset_ovf", val_t'(aovf[0]), 0);
        #3 rst = 1'b1;
        tick();
        chk("post_reset_ready", val_t'(rdy[0]), 1);

        // Basic sum
        push(0, 100); push(0, -30); push(0, 7); push(0, 3);
        expect_result("basic", 0, 80, 1'b0);
        ack("basic", 0);

        // Back-pressure, with a product offered that must be ignored
        push(0, 100); push(0, -30); push(0, 7); push(0, 3);
        prod[0] = 999;
        pv[0]   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_acc", ao[0], 80);
            chk("bp_ready", val_t'(rdy[0]), 0);
            chk("bp_valid", val_t'(av[0]), 1);
        end
        pv[0] = 1'b0;
        ack("bp", 0);

        // Saturation in the narrow instance
        push(1, 64); push(1, 64); push(1, 64); push(1, 64);
        expect_result("sat", 1, 255, 1'b1);
        ack("sat", 1);
        push(1, 1); push(1, 1); push(1, 1); push(1, 1);
        expect_result("sat_after", 1, 4, 1'b0);
        ack("sat_after", 1);

        // Clear mid-operation, competing product dropped
        push(0, 10); push(0, 20);
        clr[0]  = 1'b1;
        prod[0] = 50;
        pv[0]   = 1'b1;
        tick();
        clr[0]  = 1'b0;
        pv[0]   = 1'b0;
        chk("clear_acc", ao[0], 0);
        push(0, 1); push(0, 2); push(0, 3); push(0, 4);
        expect_result("clear", 0, 10, 1'b0);
        ack("clear", 0);

        // Asynchronous reset between edges
        push(0, 5); push(0, 5); push(0, 5);
        chk("pre_rst_acc", ao[0], 15);
        #1 rst = 1'b0;
        #1;
        chk("rst_valid", val_t'(av[0]), 0);
        chk("rst_acc", ao[0], 0);
        chk("rst_ready", val_t'(rdy[0]), 0);
        #1 rst = 1'b1;
        tick();
        push(0, 1); push(0, 1); push(0, 1); push(0, 1);
        expect_result("rst_after", 0, 4, 1'b0);
        ack("rst_after", 0);

        // Single-product results with a gap
        push(2, -7);
        expect_result("dl1_a", 2, -7, 1'b0);
        ack("dl1_a", 2);
        tick();
        tick();
        push(2, 9);
        expect_result("dl1_b", 2, 9, 1'b0);
        ack("dl1_b", 2);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
